// File: rtl/mem_stage.sv
// mem_stage: memory stage between EX and WB.
// Takes the EX->MEM entry, waits for the data-RAM read response of a load that
// EX already issued, aligns and extends the load data, picks load data or ALU
// result, and registers the outcome into the MEM->WB pipeline register.
// Also forwards the in-flight rd value to ID and flags a pending load so ID can
// stall on a load-use hazard. Only one read can be outstanding at a time.
module mem_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_b,
  // EX -> MEM
  output logic            mem_pipe_ready,
  output logic            mem_pipe_flush,
  input  logic            mem_pipe_valid,
  input  logic [XLEN-1:0] mem_pipe_pc,
  input  logic            mem_pipe_mem_read,
  input  logic [2:0]      mem_pipe_mem_opcode,
  input  logic [1:0]      mem_pipe_mem_byte_addr,
  input  logic            mem_pipe_unsign,
  input  logic            mem_pipe_rd_write,
  input  logic [4:0]      mem_pipe_rd_addr,
  input  logic [XLEN-1:0] mem_pipe_alu_result,
  input  logic            mem_pipe_exc_pending,
  // data RAM read response
  input  logic            dram_rvalid,
  input  logic [XLEN-1:0] dram_rdata,
  // MEM -> WB
  input  logic            wb_pipe_ready,
  input  logic            wb_pipe_flush,
  output logic            wb_pipe_valid,
  output logic [XLEN-1:0] wb_pipe_pc,
  output logic            wb_pipe_rd_write,
  output logic [4:0]      wb_pipe_rd_addr,
  output logic [XLEN-1:0] wb_pipe_rd_wdata,
  output logic            wb_pipe_exc_pending,
  // forwarding / hazard toward ID
  output logic            mem_rd_write,
  output logic [4:0]      mem_rd_addr,
  output logic [XLEN-1:0] mem_rd_wdata,
  output logic            mem_load_pending
);

  // IDLE : no load waiting (or the load completes this very cycle)
  // WAIT : load issued, response not yet seen
  // HOLD : response captured in rdata_buf, WB was not ready to take it
  // DRAIN: load was flushed before its response; swallow that response
  typedef enum logic [1:0] {IDLE, WAIT, HOLD, DRAIN} state_t;

  state_t          state;
  logic [XLEN-1:0] rdata_buf;

  logic            mem_valid_p0;
  logic            is_load_p0;
  logic            data_avail_p0;
  logic            in_drain_p0;
  logic            wb_load_p0;
  logic [XLEN-1:0] resp_p0;
  logic [XLEN-1:0] aligned_p0;
  logic [XLEN-1:0] rd_wdata_p0;

  // Shift the addressed lane down to bit 0, then sign- or zero-extend.
  // opcode is one-hot {WORD,HALF,BYTE}; BYTE takes priority, then HALF, else WORD.
  function automatic logic [XLEN-1:0] load_align(
    input logic [XLEN-1:0] word,
    input logic [2:0]      opcode,
    input logic [1:0]      byte_addr,
    input logic            unsign
  );
    logic [15:0]            lane;
    logic signed [7:0]      byte_s;
    logic signed [15:0]     half_s;
    logic signed [XLEN-1:0] byte_ext;
    logic signed [XLEN-1:0] half_ext;
    logic [XLEN-1:0]        res;
    lane     = 16'(word >> {byte_addr, 3'b000});
    byte_s   = lane[7:0];
    half_s   = lane;
    byte_ext = byte_s;
    half_ext = half_s;
    res      = word;
    if (opcode[0]) begin
      if (unsign) res = {{(XLEN-8){1'b0}}, lane[7:0]};
      else        res = byte_ext;
    end else if (opcode[1]) begin
      if (unsign) res = {{(XLEN-16){1'b0}}, lane};
      else        res = half_ext;
    end
    return res;
  endfunction

  // Stage p0: qualify the incoming entry, pick the response source, align it
  always_comb begin
    mem_valid_p0  = mem_pipe_valid & ~wb_pipe_flush;
    is_load_p0    = mem_valid_p0 & mem_pipe_mem_read;
    data_avail_p0 = ~is_load_p0 | dram_rvalid | (state == HOLD);
    in_drain_p0   = (state == DRAIN);
    wb_load_p0    = mem_valid_p0 & data_avail_p0 & ~in_drain_p0;
    resp_p0       = (state == HOLD) ? rdata_buf : dram_rdata;
    aligned_p0    = load_align(resp_p0, mem_pipe_mem_opcode,
                               mem_pipe_mem_byte_addr, mem_pipe_unsign);
    rd_wdata_p0   = is_load_p0 ? aligned_p0 : mem_pipe_alu_result;
  end

  // A load completes in its rvalid cycle when WB is ready, so no extra latency.
  assign mem_pipe_ready   = ~in_drain_p0 & (~mem_valid_p0 | (data_avail_p0 & wb_pipe_ready));
  assign mem_pipe_flush   = wb_pipe_flush;

  assign mem_rd_write     = mem_valid_p0 & mem_pipe_rd_write & data_avail_p0;
  assign mem_rd_addr      = mem_pipe_rd_addr;
  assign mem_rd_wdata     = rd_wdata_p0;
  assign mem_load_pending = is_load_p0 & mem_pipe_rd_write & ~data_avail_p0;

  // Load-response tracking FSM; captures the response when WB back-pressures
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= IDLE;
      rdata_buf <= '0;
    end else begin
      case (state)
        IDLE: begin
          // an rvalid with no load presented is a stray and is ignored
          if (is_load_p0) begin
            if (!dram_rvalid) begin
              state <= WAIT;
            end else if (!wb_pipe_ready) begin
              state     <= HOLD;
              rdata_buf <= dram_rdata;
            end
          end
        end
        WAIT: begin
          if (wb_pipe_flush) begin
            // response still to come must be swallowed; if it is here now, it dies with the entry
            state <= dram_rvalid ? IDLE : DRAIN;
          end else if (dram_rvalid) begin
            if (wb_pipe_ready) begin
              state <= IDLE;
            end else begin
              state     <= HOLD;
              rdata_buf <= dram_rdata;
            end
          end
        end
        HOLD: begin
          if (wb_pipe_flush || wb_pipe_ready) state <= IDLE;
        end
        DRAIN: begin
          if (dram_rvalid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p0 -> WB boundary: the MEM->WB register advances whenever WB is ready
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wb_pipe_valid       <= 1'b0;
      wb_pipe_pc          <= '0;
      wb_pipe_rd_write    <= 1'b0;
      wb_pipe_rd_addr     <= '0;
      wb_pipe_rd_wdata    <= '0;
      wb_pipe_exc_pending <= 1'b0;
    end else if (wb_pipe_ready) begin
      wb_pipe_valid       <= wb_load_p0;
      wb_pipe_pc          <= mem_pipe_pc;
      wb_pipe_rd_write    <= mem_pipe_rd_write;
      wb_pipe_rd_addr     <= mem_pipe_rd_addr;
      wb_pipe_rd_wdata    <= rd_wdata_p0;
      wb_pipe_exc_pending <= mem_pipe_exc_pending;
    end
  end

endmodule
